// File: rtl/vram_update_queue_if.sv
// rtl/vram_update_queue_if.sv - update request channel and VRAM write port bundle
interface vram_update_queue_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [10:0] upd_addr;
    logic [31:0] upd_data;
    logic [3:0]  upd_byte_en;
    logic [10:0] vram_wraddress;
    logic [31:0] vram_data;
    logic [3:0]  vram_byteena;
    logic        vram_wren;

    // Producer of updates / consumer of the VRAM write port
    modport master (
        output upd_valid, upd_addr, upd_data, upd_byte_en,
        input  upd_ready, vram_wraddress, vram_data, vram_byteena, vram_wren
    );

    // The queue itself
    modport slave (
        input  upd_valid, upd_addr, upd_data, upd_byte_en,
        output upd_ready, vram_wraddress, vram_data, vram_byteena, vram_wren
    );
endinterface

// File: rtl/vram_update_queue.sv
// rtl/vram_update_queue.sv - VRAM update FIFO committed only during the vsync window
module vram_update_queue #(
    parameter int DEPTH      = 16,
    parameter int VRAM_WORDS = 600,
    parameter int BUDGET     = 64
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    vram_update_queue_if.slave       bus,
    input  logic                     vs,
    output logic                     frame_tick,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     drop_sticky,
    input  logic                     drop_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(BUDGET + 1);
    localparam logic [10:0] LIMIT = 11'(VRAM_WORDS);

    typedef enum logic {S_IDLE, S_DRAIN} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]  budget_q, budget_d;
    logic           vs_q, vs_d;
    logic           frame_tick_q, frame_tick_d;
    logic           drop_q, drop_d;
    logic           wren_q, wren_d;
    logic [10:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [3:0]     be_q, be_d;

    // Each entry packs {addr, byte_en, data}
    logic [46:0]    mem_q [DEPTH];

    logic           full, empty, push, pop, vs_fall, head_in_range;
    logic [46:0]    head;
    logic [10:0]    head_addr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Held low during reset so nothing is accepted into a FIFO being cleared
    assign bus.upd_ready = ~full & RESET_N;
    assign push          = bus.upd_valid & bus.upd_ready;

    assign head          = mem_q[rd_ptr_q[AW-1:0]];
    assign head_addr     = head[46:36];
    assign head_in_range = (head_addr < LIMIT);
    assign vs_fall       = vs_q & ~vs;

    // Window FSM, pop decision, budget accounting and write-port staging
    always_comb begin
        state_d      = state_q;
        budget_d     = budget_q;
        pop          = 1'b0;
        wren_d       = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        be_d         = be_q;
        drop_d       = drop_clear ? 1'b0 : drop_q;
        vs_d         = vs;
        frame_tick_d = vs_fall;
        case (state_q)
            S_IDLE: begin
                if (vs_fall) begin
                    state_d  = S_DRAIN;
                    budget_d = BW'(BUDGET);
                end
            end
            S_DRAIN: begin
                if (vs || empty) begin
                    state_d = S_IDLE;
                end else begin
                    pop = 1'b1;
                    if (head_in_range) begin
                        wren_d   = 1'b1;
                        addr_d   = head_addr;
                        be_d     = head[35:32];
                        data_d   = head[31:0];
                        budget_d = budget_q - BW'(1);
                        if (budget_q == BW'(1)) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        // A new drop outranks a simultaneous clear
                        drop_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            budget_q     <= '0;
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
            drop_q       <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            budget_q     <= budget_d;
            vs_q         <= vs_d;
            frame_tick_q <= frame_tick_d;
            drop_q       <= drop_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            be_q         <= be_d;
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.upd_addr, bus.upd_byte_en, bus.upd_data};
        end
    end

    assign bus.vram_wren      = wren_q;
    assign bus.vram_wraddress = addr_q;
    assign bus.vram_data      = data_q;
    assign bus.vram_byteena   = be_q;
    assign frame_tick         = frame_tick_q;
    assign drop_sticky        = drop_q;
    assign fifo_count         = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_vram_update_queue.sv
// tb/tb_vram_update_queue.sv - self-checking bench for vram_update_queue
module tb_vram_update_queue;
    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       vs = 1'b1;
    logic       drop_clear = 1'b0;
    logic       frame_tick;
    logic [4:0] fifo_count;
    logic       drop_sticky;

    vram_update_queue_if bus();

    vram_update_queue #(.DEPTH(16), .VRAM_WORDS(600), .BUDGET(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus), .vs(vs),
        .frame_tick(frame_tick), .fifo_count(fifo_count),
        .drop_sticky(drop_sticky), .drop_clear(drop_clear)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int n_writes = 0;
    logic sb_en = 1'b0;
    logic [46:0] sb[$];

    typedef struct {
        logic v; logic [10:0] a; logic [31:0] d; logic [3:0] be; logic vs; logic dc;
        logic e_rdy; logic e_wren; logic [10:0] e_addr; logic [31:0] e_data; logic [3:0] e_be;
        logic [4:0] e_cnt; logic e_tick; logic e_drop;
    } vec_t;
    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock, then observe at the falling edge; scoreboard any VRAM write
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        if (sb_en && bus.vram_wren) begin
            n_writes++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(bus.vram_wraddress), 32'h7ff);
            end else begin
                logic [46:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.vram_wraddress), 32'(e[46:36]));
                chk("wr_be", 32'(bus.vram_byteena), 32'(e[35:32]));
                chk("wr_data", bus.vram_data, e[31:0]);
            end
        end
    endtask

    task automatic push(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be, input logic acc);
        chk("push_ready", 32'(bus.upd_ready), 32'(acc));
        bus.upd_valid = 1'b1; bus.upd_addr = a; bus.upd_data = d; bus.upd_byte_en = be;
        step();
        bus.upd_valid = 1'b0;
        if (acc) sb.push_back({a, be, d});
    endtask

    task automatic window();
        vs = 1'b0;
        repeat (8) step();
        vs = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        bus.upd_valid = 1'b0; bus.upd_addr = '0; bus.upd_data = '0; bus.upd_byte_en = '0;

        vt[0]  = '{1'b1, 11'd0,   32'hA0A0_0000, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   32'h0,         4'h0, 5'd1, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 11'd1,   32'hA1A1_0001, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   32'h0,         4'h0, 5'd2, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 11'd599, 32'hA2A2_0257, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   32'h0,         4'h0, 5'd3, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   32'h0,         4'h0, 5'd3, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   32'h0,         4'h0, 5'd3, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0,   32'hA0A0_0000, 4'hF, 5'd2, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd1,   32'hA1A1_0001, 4'h3, 5'd1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd599, 32'hA2A2_0257, 4'hC, 5'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd599, 32'hA2A2_0257, 4'hC, 5'd0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd599, 32'hA2A2_0257, 4'hC, 5'd0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 11'd5,   32'h5555_0005, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 11'd599, 32'hA2A2_0257, 4'hC, 5'd1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 11'd600, 32'h6666_0258, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd599, 32'hA2A2_0257, 4'hC, 5'd2, 1'b0, 1'b0};
        vt[12] = '{1'b1, 11'd6,   32'h7777_0006, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 11'd599, 32'hA2A2_0257, 4'hC, 5'd3, 1'b0, 1'b0};
        vt[13] = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd599, 32'hA2A2_0257, 4'hC, 5'd3, 1'b1, 1'b0};
        vt[14] = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd5,   32'h5555_0005, 4'hF, 5'd2, 1'b0, 1'b0};
        vt[15] = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd5,   32'h5555_0005, 4'hF, 5'd1, 1'b0, 1'b1};
        vt[16] = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd6,   32'h7777_0006, 4'h2, 5'd0, 1'b0, 1'b1};
        vt[17] = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 11'd6,   32'h7777_0006, 4'h2, 5'd0, 1'b0, 1'b1};
        vt[18] = '{1'b0, 11'd0,   32'h0,         4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd6,   32'h7777_0006, 4'h2, 5'd0, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(bus.upd_ready), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_wren", 32'(bus.vram_wren), 32'd0);
        chk("rst_addr", 32'(bus.vram_wraddress), 32'd0);
        chk("rst_data", bus.vram_data, 32'd0);
        chk("rst_be", 32'(bus.vram_byteena), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_drop", 32'(drop_sticky), 32'd0);
        RESET_N = 1'b1;

        // Table: basic window, ordering, out-of-range drop, clear-vs-set
        for (int i = 0; i < 19; i++) begin
            bus.upd_valid = vt[i].v; bus.upd_addr = vt[i].a; bus.upd_data = vt[i].d;
            bus.upd_byte_en = vt[i].be; vs = vt[i].vs; drop_clear = vt[i].dc;
            step();
            chk($sformatf("v%0d_ready", i), 32'(bus.upd_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_wren", i), 32'(bus.vram_wren), 32'(vt[i].e_wren));
            chk($sformatf("v%0d_addr", i), 32'(bus.vram_wraddress), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_data", i), bus.vram_data, vt[i].e_data);
            chk($sformatf("v%0d_be", i), 32'(bus.vram_byteena), 32'(vt[i].e_be));
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_tick", i), 32'(frame_tick), 32'(vt[i].e_tick));
            chk($sformatf("v%0d_drop", i), 32'(drop_sticky), 32'(vt[i].e_drop));
        end
        bus.upd_valid = 1'b0; drop_clear = 1'b0; vs = 1'b1;
        sb_en = 1'b1;

        // Budget: 10 queued, 4 per window
        for (int i = 0; i < 10; i++) push(11'(100 + i), 32'hB000_0000 + 32'(i), 4'hF, 1'b1);
        chk("bud_count_q", 32'(fifo_count), 32'd10);
        n_writes = 0;
        window();
        chk("bud_writes1", 32'(n_writes), 32'd4);
        chk("bud_count1", 32'(fifo_count), 32'd6);
        window();
        chk("bud_writes2", 32'(n_writes), 32'd8);
        chk("bud_count2", 32'(fifo_count), 32'd2);

        // vs rises after 2 writes; concurrent push+pop keeps count
        for (int i = 0; i < 6; i++) push(11'(200 + i), 32'hC000_0000 + 32'(i), 4'h5, 1'b1);
        chk("vsr_count_q", 32'(fifo_count), 32'd8);
        n_writes = 0;
        vs = 1'b0;
        step();
        chk("vsr_tick", 32'(frame_tick), 32'd1);
        push(11'd300, 32'hD000_0300, 4'hA, 1'b1);
        chk("pushpop_count", 32'(fifo_count), 32'd8);
        step();
        chk("vsr_count_2", 32'(fifo_count), 32'd7);
        vs = 1'b1;
        repeat (4) step();
        chk("vsr_writes", 32'(n_writes), 32'd2);
        chk("vsr_count_end", 32'(fifo_count), 32'd7);
        window();
        window();
        chk("drain_empty", 32'(fifo_count), 32'd0);
        chk("sb_empty1", 32'(sb.size()), 32'd0);

        // Full FIFO: 17th push rejected, ready returns after first pop
        for (int i = 0; i < 16; i++) push(11'(i * 37), 32'hE000_0000 + 32'(i), 4'hF, 1'b1);
        chk("full_ready", 32'(bus.upd_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd16);
        push(11'd7, 32'hBAD0_0007, 4'hF, 1'b0);
        chk("full_reject_count", 32'(fifo_count), 32'd16);
        vs = 1'b0;
        step();
        chk("full_ready_tick", 32'(bus.upd_ready), 32'd0);
        step();
        chk("full_ready_pop", 32'(bus.upd_ready), 32'd1);
        chk("full_count_pop", 32'(fifo_count), 32'd15);
        repeat (6) step();
        vs = 1'b1;
        repeat (2) step();
        repeat (3) window();
        chk("full_drained", 32'(fifo_count), 32'd0);
        chk("sb_empty2", 32'(sb.size()), 32'd0);

        // Reset mid-drain with 5 queued
        for (int i = 0; i < 5; i++) push(11'(400 + i), 32'hF000_0000 + 32'(i), 4'hF, 1'b1);
        vs = 1'b0;
        step();
        step();
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_wren", 32'(bus.vram_wren), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.upd_ready), 32'd0);
        sb.delete();
        vs = 1'b1;
        repeat (2) step();
        chk("in_rst_wren", 32'(bus.vram_wren), 32'd0);
        RESET_N = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.upd_ready), 32'd1);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        repeat (3) step();
        chk("post_rst_wren", 32'(bus.vram_wren), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
